counter_reg_v02: RTL and testbench

COUNTER_REG_V02 -- requirements
Module: counter_reg_v02

---
 rtl/counter_reg_v02.sv | 215 +++++++++++++++++++++
 tb/tb_counter_reg_v02.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_reg_v02.sv
// counter_reg_v02 -- loadable up/down counter with a call/return stack.
//
// The counter steps up or down by STEP, loads DATA_IN directly, or takes part
// in a call/return sequence. On a call (PUSH), counter+STEP is saved on a
// LIFO return stack and DATA_IN is loaded. On a return (POP), the counter is
// reloaded from the top of the stack. At most one operation executes per
// cycle, in this priority order:
//   PUSH&POP (illegal) > POP > PUSH > DATA_STORE_VAL > INC/DEC.
//
// Parameters
//   DATA_WIDTH   counter, data and stack entry width
//   STEP         increment/decrement magnitude (1 .. 2^DATA_WIDTH-1)
//   LOOP_COUNTER 1: modulo wrap on overflow, 0: saturate at the bounds
//   STACK_DEPTH  number of return-stack entries (>= 2)
//
// Ports
//   CLOCK           rising-edge clock
//   RESET           asynchronous active-high reset
//   DATA_INC/DEC    step request (both high together: no operation)
//   DATA_STORE_VAL  load DATA_IN
//   PUSH / POP      call / return
//   CLR_FLAGS       clear OVF and STACK_ERR (a new set in the same cycle wins)
//   SHOW_DATA       tristate enable for DATA_OUT
//   DATA_IN         load / call target
//   DATA_OUT        counter value or all-Z
//   COUNT_VALUE     counter value, always driven
//   TERM_MAX/MIN    counter is all-ones / zero
//   OVF             sticky arithmetic bound flag
//   STACK_FULL/EMPTY stack occupancy
//   STACK_ERR       sticky stack misuse flag
module counter_reg_v02 #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STEP         = 1,
  parameter bit          LOOP_COUNTER = 1'b0,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  DATA_INC,
  input  logic                  DATA_DEC,
  input  logic                  DATA_STORE_VAL,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR_FLAGS,
  input  logic                  SHOW_DATA,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic [DATA_WIDTH-1:0] COUNT_VALUE,
  output logic                  TERM_MAX,
  output logic                  TERM_MIN,
  output logic                  OVF,
  output logic                  STACK_FULL,
  output logic                  STACK_EMPTY,
  output logic                  STACK_ERR
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  localparam logic [DATA_WIDTH:0] STEP_X  = (DATA_WIDTH + 1)'(STEP);
  localparam logic [SP_W-1:0]     SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0]     SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_CONFLICT,
    OP_POP,
    OP_PUSH,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_e;

  logic [DATA_WIDTH-1:0] count_q;
  logic [DATA_WIDTH-1:0] count_d;
  logic [SP_W-1:0]       sp_q;
  logic [SP_W-1:0]       sp_d;
  logic                  ovf_q;
  logic                  err_q;
  logic                  ovf_set;
  logic                  err_set;

  // Stack storage is deliberately not reset; nothing observable reads an
  // entry at or above the pointer.
  logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      top_idx;
  logic [DATA_WIDTH-1:0] stack_wdata;

  logic                  stack_full;
  logic                  stack_empty;

  logic [DATA_WIDTH:0]   inc_sum;
  logic [DATA_WIDTH:0]   dec_diff;
  logic                  inc_carry;
  logic                  dec_borrow;
  logic [DATA_WIDTH-1:0] inc_next;
  logic [DATA_WIDTH-1:0] dec_next;

  op_e                   op;

  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign wr_idx      = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_q - SP_ONE);

  // Priority decode: exactly one operation (or none) per cycle.
  always_comb begin
    op = OP_IDLE;
    if (PUSH && POP) begin
      op = OP_CONFLICT;
    end else if (POP) begin
      op = OP_POP;
    end else if (PUSH) begin
      op = OP_PUSH;
    end else if (DATA_STORE_VAL) begin
      op = OP_LOAD;
    end else if (DATA_INC && !DATA_DEC) begin
      op = OP_INC;
    end else if (DATA_DEC && !DATA_INC) begin
      op = OP_DEC;
    end
  end

  // One extra bit: the MSB of the sum is the carry out, and the MSB of the
  // difference is the borrow (STEP never exceeds the counter range).
  always_comb begin
    inc_sum    = {1'b0, count_q} + STEP_X;
    dec_diff   = {1'b0, count_q} - STEP_X;
    inc_carry  = inc_sum[DATA_WIDTH];
    dec_borrow = dec_diff[DATA_WIDTH];
    inc_next   = (inc_carry && !LOOP_COUNTER) ? '1 : inc_sum[DATA_WIDTH-1:0];
    dec_next   = (dec_borrow && !LOOP_COUNTER) ? '0 : dec_diff[DATA_WIDTH-1:0];
  end

  // The return address is always the wrapped counter+STEP, independent of
  // the overflow mode.
  assign stack_wdata = inc_sum[DATA_WIDTH-1:0];

  always_comb begin
    count_d = count_q;
    sp_d    = sp_q;
    ovf_set = 1'b0;
    err_set = 1'b0;
    wr_en   = 1'b0;
    unique case (op)
      OP_CONFLICT: begin
        err_set = 1'b1;
      end
      OP_POP: begin
        if (stack_empty) begin
          err_set = 1'b1;
        end else begin
          count_d = stack_mem[top_idx];
          sp_d    = sp_q - SP_ONE;
        end
      end
      OP_PUSH: begin
        if (stack_full) begin
          err_set = 1'b1;
        end else begin
          count_d = DATA_IN;
          sp_d    = sp_q + SP_ONE;
          wr_en   = 1'b1;
        end
      end
      OP_LOAD: begin
        count_d = DATA_IN;
      end
      OP_INC: begin
        count_d = inc_next;
        ovf_set = inc_carry;
      end
      OP_DEC: begin
        count_d = dec_next;
        ovf_set = dec_borrow;
      end
      OP_IDLE: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_set | (ovf_q & ~CLR_FLAGS);
      err_q   <= err_set | (err_q & ~CLR_FLAGS);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en && !RESET) begin
      stack_mem[wr_idx] <= stack_wdata;
    end
  end

  assign COUNT_VALUE = count_q;
  assign DATA_OUT    = SHOW_DATA ? count_q : 'z;
  assign TERM_MAX    = (count_q == '1);
  assign TERM_MIN    = (count_q == '0);
  assign OVF         = ovf_q;
  assign STACK_ERR   = err_q;
  assign STACK_FULL  = stack_full;
  assign STACK_EMPTY = stack_empty;

endmodule

// File: tb/tb_counter_reg_v02.sv
// Testbench for counter_reg_v02. Two instances share the same stimulus:
// dut_sat (defaults: saturating, STEP=1) and dut_wrap (wrapping, STEP=3).
// A behavioural model predicts each cycle's result, queues it, and the
// queued value is compared once the DUT has taken the clock edge.
module tb_counter_reg_v02;

  logic       CLOCK;
  logic       RESET;
  logic       DATA_INC;
  logic       DATA_DEC;
  logic       DATA_STORE_VAL;
  logic       PUSH;
  logic       POP;
  logic       CLR_FLAGS;
  logic       SHOW_DATA;
  logic [7:0] DATA_IN;

  wire  [7:0] dout_a;
  logic [7:0] cnt_a;
  logic       max_a, min_a, ovf_a, full_a, empty_a, err_a;
  wire  [7:0] dout_b;
  logic [7:0] cnt_b;
  logic       max_b, min_b, ovf_b, full_b, empty_b, err_b;

  counter_reg_v02 dut_sat (
    .CLOCK(CLOCK), .RESET(RESET), .DATA_INC(DATA_INC), .DATA_DEC(DATA_DEC),
    .DATA_STORE_VAL(DATA_STORE_VAL), .PUSH(PUSH), .POP(POP),
    .CLR_FLAGS(CLR_FLAGS), .SHOW_DATA(SHOW_DATA), .DATA_IN(DATA_IN),
    .DATA_OUT(dout_a), .COUNT_VALUE(cnt_a), .TERM_MAX(max_a), .TERM_MIN(min_a),
    .OVF(ovf_a), .STACK_FULL(full_a), .STACK_EMPTY(empty_a), .STACK_ERR(err_a)
  );

  counter_reg_v02 #(
    .DATA_WIDTH(8),
    .STEP(3),
    .LOOP_COUNTER(1'b1),
    .STACK_DEPTH(4)
  ) dut_wrap (
    .CLOCK(CLOCK), .RESET(RESET), .DATA_INC(DATA_INC), .DATA_DEC(DATA_DEC),
    .DATA_STORE_VAL(DATA_STORE_VAL), .PUSH(PUSH), .POP(POP),
    .CLR_FLAGS(CLR_FLAGS), .SHOW_DATA(SHOW_DATA), .DATA_IN(DATA_IN),
    .DATA_OUT(dout_b), .COUNT_VALUE(cnt_b), .TERM_MAX(max_b), .TERM_MIN(min_b),
    .OVF(ovf_b), .STACK_FULL(full_b), .STACK_EMPTY(empty_b), .STACK_ERR(err_b)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_step [2] = '{1, 3};
  bit m_loop [2] = '{1'b0, 1'b1};
  int m_cnt  [2];
  int m_sp   [2];
  int m_stk  [2][4];
  bit m_ovf  [2];
  bit m_err  [2];

  typedef struct packed {
    logic [7:0] cnt;
    logic       ovf;
    logic       err;
    logic       full;
    logic       empty;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_sp[k]  = 0;
      m_ovf[k] = 1'b0;
      m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit pu, input bit po, input bit st,
                            input bit up, input bit dn, input bit cl, input int d);
    bit os;
    bit es;
    int r;
    os = 1'b0;
    es = 1'b0;
    if (pu && po) begin
      es = 1'b1;
    end else if (po) begin
      if (m_sp[k] == 0) es = 1'b1;
      else begin
        m_sp[k]  = m_sp[k] - 1;
        m_cnt[k] = m_stk[k][m_sp[k]];
      end
    end else if (pu) begin
      if (m_sp[k] == 4) es = 1'b1;
      else begin
        m_stk[k][m_sp[k]] = (m_cnt[k] + m_step[k]) % 256;
        m_sp[k]  = m_sp[k] + 1;
        m_cnt[k] = d;
      end
    end else if (st) begin
      m_cnt[k] = d;
    end else if (up && !dn) begin
      r = m_cnt[k] + m_step[k];
      if (r > 255) begin
        os = 1'b1;
        m_cnt[k] = m_loop[k] ? r - 256 : 255;
      end else m_cnt[k] = r;
    end else if (dn && !up) begin
      r = m_cnt[k] - m_step[k];
      if (r < 0) begin
        os = 1'b1;
        m_cnt[k] = m_loop[k] ? r + 256 : 0;
      end else m_cnt[k] = r;
    end
    m_ovf[k] = os || (m_ovf[k] && !cl);
    m_err[k] = es || (m_err[k] && !cl);
  endtask

  function automatic exp_t mk_exp(input int k);
    exp_t e;
    e.cnt   = 8'(m_cnt[k]);
    e.ovf   = m_ovf[k];
    e.err   = m_err[k];
    e.full  = (m_sp[k] == 4);
    e.empty = (m_sp[k] == 0);
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    e = q_a.pop_front();
    chk("a_cnt",   cnt_a,   e.cnt);
    chk("a_max",   max_a,   e.cnt == 8'hFF);
    chk("a_min",   min_a,   e.cnt == 8'h00);
    chk("a_ovf",   ovf_a,   e.ovf);
    chk("a_err",   err_a,   e.err);
    chk("a_full",  full_a,  e.full);
    chk("a_empty", empty_a, e.empty);
    if (SHOW_DATA) chk("a_dout", dout_a, e.cnt);
    e = q_b.pop_front();
    chk("b_cnt",   cnt_b,   e.cnt);
    chk("b_ovf",   ovf_b,   e.ovf);
    chk("b_err",   err_b,   e.err);
    chk("b_full",  full_b,  e.full);
    chk("b_empty", empty_b, e.empty);
  endtask

  // One clock of stimulus: drive at the falling edge, predict, then compare
  // just after the rising edge.
  task automatic cyc(input bit pu, input bit po, input bit st, input bit up,
                     input bit dn, input bit cl, input logic [7:0] d);
    @(negedge CLOCK);
    PUSH = pu; POP = po; DATA_STORE_VAL = st;
    DATA_INC = up; DATA_DEC = dn; CLR_FLAGS = cl; DATA_IN = d;
    for (int k = 0; k < 2; k++) model_step(k, pu, po, st, up, dn, cl, int'(d));
    q_a.push_back(mk_exp(0));
    q_b.push_back(mk_exp(1));
    @(posedge CLOCK);
    #1;
    compare_outputs();
  endtask

  task automatic idle_inputs();
    PUSH = 0; POP = 0; DATA_STORE_VAL = 0; DATA_INC = 0; DATA_DEC = 0; CLR_FLAGS = 0;
  endtask

  // Shorthand operations: (push, pop, store, inc, dec, clr, data)
  task automatic op_store(input logic [7:0] d); cyc(0, 0, 1, 0, 0, 0, d); endtask
  task automatic op_inc();                      cyc(0, 0, 0, 1, 0, 0, 8'h00); endtask
  task automatic op_dec();                      cyc(0, 0, 0, 0, 1, 0, 8'h00); endtask
  task automatic op_push(input logic [7:0] d);  cyc(1, 0, 0, 0, 0, 0, d); endtask
  task automatic op_pop();                      cyc(0, 1, 0, 0, 0, 0, 8'h00); endtask
  task automatic op_clr();                      cyc(0, 0, 0, 0, 0, 1, 8'h00); endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] pop_order [4];

  initial begin
    RESET = 1'b0;
    idle_inputs();
    SHOW_DATA = 1'b1;
    DATA_IN = 8'h00;
    #1 RESET = 1'b1;
    #1;
    model_reset();
    chk("rst_cnt",   cnt_a,   8'h00);
    chk("rst_min",   min_a,   1'b1);
    chk("rst_max",   max_a,   1'b0);
    chk("rst_empty", empty_a, 1'b1);
    chk("rst_full",  full_a,  1'b0);
    chk("rst_ovf",   ovf_a,   1'b0);
    chk("rst_err",   err_a,   1'b0);
    @(negedge CLOCK);
    RESET = 1'b0;

    // Saturating increment at the top.
    op_store(8'hFE);
    op_inc();
    chk("sat_inc1_cnt", cnt_a, 8'hFF);
    chk("sat_inc1_ovf", ovf_a, 1'b0);
    op_inc();
    chk("sat_inc2_ovf", ovf_a, 1'b1);
    op_inc();
    chk("sat_inc3_cnt", cnt_a, 8'hFF);
    chk("sat_inc3_max", max_a, 1'b1);

    // Wrapping STEP=3, and set-wins-over-clear.
    op_clr();
    op_store(8'hFE);
    op_inc();
    chk("wrap_inc_cnt", cnt_b, 8'h01);
    chk("wrap_inc_ovf", ovf_b, 1'b1);
    cyc(0, 0, 0, 0, 1, 1, 8'h00);
    chk("wrap_dec_cnt", cnt_b, 8'hFE);
    chk("wrap_dec_ovf", ovf_b, 1'b1);

    // Call / return.
    op_clr();
    op_store(8'h10);
    op_push(8'h40);
    chk("call_cnt",   cnt_a,   8'h40);
    chk("call_empty", empty_a, 1'b0);
    op_pop();
    chk("ret_cnt",   cnt_a,   8'h11);
    chk("ret_empty", empty_a, 1'b1);
    op_pop();
    chk("ret_empty_cnt", cnt_a, 8'h11);
    chk("ret_empty_err", err_a, 1'b1);

    // Fill, overflow the stack, unwind in LIFO order.
    op_clr();
    op_store(8'h20);
    for (int i = 0; i < 4; i++) op_push(8'hA0 + 8'(i));
    chk("fill_full", full_a, 1'b1);
    op_push(8'h55);
    chk("over_cnt", cnt_a, 8'hA3);
    chk("over_err", err_a, 1'b1);
    pop_order = '{8'hA3, 8'hA2, 8'hA1, 8'h21};
    for (int i = 0; i < 4; i++) begin
      op_pop();
      chk("unwind_cnt", cnt_a, 32'(pop_order[i]));
    end
    chk("unwind_empty", empty_a, 1'b1);

    // Conflicting and combined requests.
    op_clr();
    op_push(8'h60);
    cyc(1, 1, 0, 0, 0, 0, 8'h99);
    chk("pushpop_cnt", cnt_a, 8'h60);
    chk("pushpop_err", err_a, 1'b1);
    chk("pushpop_empty", empty_a, 1'b0);
    op_clr();
    cyc(0, 0, 0, 1, 1, 0, 8'h00);
    chk("incdec_cnt", cnt_a, 8'h60);
    chk("incdec_ovf", ovf_a, 1'b0);
    cyc(0, 0, 1, 1, 0, 0, 8'h77);
    chk("store_inc_cnt", cnt_a, 8'h77);
    cyc(0, 1, 1, 0, 0, 0, 8'h99);
    chk("pop_store_cnt", cnt_a, 8'h22);

    // Underflow at the bottom.
    op_store(8'h01);
    op_dec();
    chk("sat_dec1_cnt", cnt_a, 8'h00);
    op_dec();
    chk("sat_dec2_cnt", cnt_a, 8'h00);
    chk("sat_dec2_ovf", ovf_a, 1'b1);
    chk("sat_dec2_min", min_a, 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 80; i++) begin
      SHOW_DATA = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
          8'($urandom));
    end

    // Tristate output.
    SHOW_DATA = 1'b1;
    op_clr();
    op_store(8'h33);
    cyc(1, 1, 0, 0, 0, 0, 8'h00);
    SHOW_DATA = 1'b0;
    #1;
    chk("dout_off", dout_a === 8'h33, 1'b0);
    SHOW_DATA = 1'b1;
    #1;
    chk("dout_on", dout_a, 8'h33);

    // Asynchronous reset in the middle of a cycle with a request pending.
    idle_inputs();
    DATA_INC = 1'b1;
    RESET = 1'b1;
    #1;
    model_reset();
    chk("arst_cnt",   cnt_a,   8'h00);
    chk("arst_cnt_b", cnt_b,   8'h00);
    chk("arst_min",   min_a,   1'b1);
    chk("arst_max",   max_a,   1'b0);
    chk("arst_empty", empty_a, 1'b1);
    chk("arst_full",  full_a,  1'b0);
    chk("arst_ovf",   ovf_a,   1'b0);
    chk("arst_err",   err_a,   1'b0);
    @(posedge CLOCK);
    #1;
    chk("arst_hold_cnt", cnt_a, 8'h00);
    @(negedge CLOCK);
    RESET = 1'b0;
    idle_inputs();
    op_inc();
    chk("resume_cnt", cnt_a, 8'h01);
    chk("resume_cnt_b", cnt_b, 8'h03);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
